vote_tally_engine: RTL and testbench

//   Parametrised N-candidate vote tally core; next generation of the 4-candidate voting machine.

---
 rtl/vote_pkg.sv | 36 +++
 rtl/vote_sat_counter.sv | 24 ++
 rtl/vote_tally_engine.sv | 198 +++++++++++++++++++
 tb/tb_vote_tally_engine.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally engine.
package vote_pkg;

  // Widest voter vector the helper functions accept.
  localparam int unsigned MaxCand = 32;
  localparam int unsigned MaxIdxW = 5;

  typedef enum logic [1:0] {
    ModeVote  = 2'b00,
    ModeCount = 2'b01,
    ModeClear = 2'b10,
    ModeTest  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StOpen = 2'b00,
    StScan = 2'b01,
    StDone = 2'b10
  } state_e;

  // True when exactly one bit is set.
  function automatic logic onehot_valid(input logic [MaxCand-1:0] v);
    return (v != '0) && ((v & (v - MaxCand'(1))) == '0);
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot input.
  function automatic logic [MaxIdxW-1:0] onehot_to_idx(input logic [MaxCand-1:0] v);
    logic [MaxIdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MaxCand; i++) begin
      if (v[i]) idx = MaxIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module vote_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  assign full = &q;

  // Count register: reset/clear to zero, increment unless already full.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && !full) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vote_tally_engine.sv
// N-candidate vote tally: edge-triggered voting, sequential winner scan, count readout.
module vote_tally_engine
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TOT_W    = 12,
  localparam int unsigned IDX_W   = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [NUM_CAND-1:0] voter,
  input  logic                confirm,
  input  logic [IDX_W-1:0]    rd_sel,
  output logic                vote_ack,
  output logic                vote_err,
  output logic [NUM_CAND-1:0] winner,
  output logic                tie,
  output logic                result_valid,
  output logic [CNT_W-1:0]    rd_count,
  output logic [TOT_W-1:0]    total
);

  mode_e  mode_s;
  state_e state_q, state_d;

  logic                confirm_q, confirm_rise;
  logic [CNT_W-1:0]    cnt [NUM_CAND];
  logic [NUM_CAND-1:0] cnt_full, cnt_inc;
  logic                tot_full, tot_inc, clr;
  logic                voter_ok;
  logic [IDX_W-1:0]    vidx;

  logic [IDX_W-1:0]    i_q, i_d, bidx_q, bidx_d, nbidx;
  logic [CNT_W-1:0]    best_q, best_d, nbest, scan_cnt;
  logic                tflag_q, tflag_d, ntflag;

  logic                ack_d, err_d, tie_d, valid_d;
  logic [NUM_CAND-1:0] winner_d;
  logic [CNT_W-1:0]    rd_count_d;

  assign mode_s       = mode_e'(mode);
  assign confirm_rise = confirm & ~confirm_q;
  assign voter_ok     = onehot_valid(MaxCand'(voter));
  assign vidx         = IDX_W'(onehot_to_idx(MaxCand'(voter)));
  assign scan_cnt     = cnt[i_q];

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    vote_sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (cnt_inc[g]),
      .clr  (clr),
      .q    (cnt[g]),
      .full (cnt_full[g])
    );
  end

  vote_sat_counter #(.WIDTH(TOT_W)) u_total (
    .clk  (clk),
    .rst  (rst),
    .inc  (tot_inc),
    .clr  (clr),
    .q    (total),
    .full (tot_full)
  );

  // One scan step: fold the current candidate into the running best/tie state.
  always_comb begin
    nbest  = best_q;
    nbidx  = bidx_q;
    ntflag = tflag_q;
    if (scan_cnt > best_q) begin
      nbest  = scan_cnt;
      nbidx  = i_q;
      ntflag = 1'b0;
    end else if ((scan_cnt == best_q) && (best_q != '0)) begin
      ntflag = 1'b1;
    end
  end

  // Next-state, vote acceptance and result logic.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    best_d   = best_q;
    bidx_d   = bidx_q;
    tflag_d  = tflag_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    winner_d = winner;
    tie_d    = tie;
    valid_d  = result_valid;
    cnt_inc  = '0;
    tot_inc  = 1'b0;
    clr      = 1'b0;

    if (mode_s == ModeClear) begin
      clr      = 1'b1;
      state_d  = StOpen;
      i_d      = '0;
      best_d   = '0;
      bidx_d   = '0;
      tflag_d  = 1'b0;
      winner_d = '0;
      tie_d    = 1'b0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        StOpen: begin
          winner_d = '0;
          tie_d    = 1'b0;
          valid_d  = 1'b0;
          if (confirm_rise) begin
            if ((mode_s == ModeVote) && voter_ok && !cnt_full[vidx] && !tot_full) begin
              cnt_inc[vidx] = 1'b1;
              tot_inc       = 1'b1;
              ack_d         = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          if (mode_s == ModeCount) begin
            state_d = StScan;
            i_d     = '0;
            best_d  = '0;
            bidx_d  = '0;
            tflag_d = 1'b0;
          end
        end
        StScan: begin
          err_d   = confirm_rise;
          best_d  = nbest;
          bidx_d  = nbidx;
          tflag_d = ntflag;
          if (i_q == IDX_W'(NUM_CAND - 1)) begin
            state_d  = StDone;
            valid_d  = 1'b1;
            tie_d    = ntflag;
            winner_d = '0;
            if (!ntflag && (nbest != '0)) winner_d[nbidx] = 1'b1;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end
        StDone: begin
          err_d = confirm_rise;
          if ((mode_s == ModeVote) || (mode_s == ModeTest)) begin
            state_d  = StOpen;
            winner_d = '0;
            tie_d    = 1'b0;
            valid_d  = 1'b0;
          end
        end
        default: state_d = StOpen;
      endcase
    end
  end

  // Readout mux; out-of-range selects read as zero.
  always_comb begin
    rd_count_d = '0;
    if (32'(rd_sel) < NUM_CAND) rd_count_d = cnt[rd_sel];
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StOpen;
      confirm_q    <= 1'b0;
      i_q          <= '0;
      best_q       <= '0;
      bidx_q       <= '0;
      tflag_q      <= 1'b0;
      vote_ack     <= 1'b0;
      vote_err     <= 1'b0;
      winner       <= '0;
      tie          <= 1'b0;
      result_valid <= 1'b0;
      rd_count     <= '0;
    end else begin
      state_q      <= state_d;
      confirm_q    <= confirm;
      i_q          <= i_d;
      best_q       <= best_d;
      bidx_q       <= bidx_d;
      tflag_q      <= tflag_d;
      vote_ack     <= ack_d;
      vote_err     <= err_d;
      winner       <= winner_d;
      tie          <= tie_d;
      result_valid <= valid_d;
      rd_count     <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_vote_tally_engine.sv
// Directed self-checking bench for vote_tally_engine (default and CNT_W=2 instances).
module tb_vote_tally_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] voter;
  logic       confirm;
  logic [1:0] rd_sel;

  logic        ack_a, err_a, tie_a, valid_a;
  logic [3:0]  win_a;
  logic [7:0]  rdc_a;
  logic [11:0] tot_a;

  logic        ack_b, err_b, tie_b, valid_b;
  logic [3:0]  win_b;
  logic [1:0]  rdc_b;
  logic [11:0] tot_b;

  int n_total = 0;
  int n_bad   = 0;
  int acks, errs;

  always #5 clk = ~clk;

  vote_tally_engine #(.NUM_CAND(4), .CNT_W(8), .TOT_W(12)) dut_a (
    .clk (clk), .rst (rst), .mode (mode), .voter (voter), .confirm (confirm),
    .rd_sel (rd_sel), .vote_ack (ack_a), .vote_err (err_a), .winner (win_a),
    .tie (tie_a), .result_valid (valid_a), .rd_count (rdc_a), .total (tot_a)
  );

  vote_tally_engine #(.NUM_CAND(4), .CNT_W(2), .TOT_W(12)) dut_b (
    .clk (clk), .rst (rst), .mode (mode), .voter (voter), .confirm (confirm),
    .rd_sel (rd_sel), .vote_ack (ack_b), .vote_err (err_b), .winner (win_b),
    .tie (tie_b), .result_valid (valid_b), .rd_count (rdc_b), .total (tot_b)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vote(input logic [3:0] v);
    voter   = v;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
  endtask

  task automatic clear_then_vote_mode();
    mode = 2'b10;
    tick();
    mode = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; voter = '0; confirm = 1'b0; rd_sel = '0;
    tick(2);
    chk("rst_ack", 32'(ack_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_winner", 32'(win_a), 0);
    chk("rst_tie", 32'(tie_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_rdcount", 32'(rdc_a), 0);
    chk("rst_total", 32'(tot_a), 0);
    rst = 1'b0;
    tick();

    // 1: clear winner with latency check
    voter = 4'b0100; confirm = 1'b1; tick();
    chk("t1_ack_pulse", 32'(ack_a), 1);
    chk("t1_err_quiet", 32'(err_a), 0);
    confirm = 1'b0; tick();
    chk("t1_ack_low", 32'(ack_a), 0);
    vote(4'b0100); vote(4'b0100); vote(4'b0001);
    mode = 2'b01;
    tick(4);
    chk("t1_valid_early", 32'(valid_a), 0);
    tick();
    chk("t1_valid", 32'(valid_a), 1);
    chk("t1_winner", 32'(win_a), 32'b0100);
    chk("t1_tie", 32'(tie_a), 0);
    chk("t1_total", 32'(tot_a), 4);
    rd_sel = 2'd2; tick();
    chk("t1_rdcount", 32'(rdc_a), 3);
    chk("t1_valid_hold", 32'(valid_a), 1);
    clear_then_vote_mode();
    chk("t1_clr_total", 32'(tot_a), 0);

    // 2: two-way tie
    vote(4'b0010); vote(4'b0010); vote(4'b1000); vote(4'b1000);
    mode = 2'b01;
    tick(5);
    chk("t2_valid", 32'(valid_a), 1);
    chk("t2_winner", 32'(win_a), 0);
    chk("t2_tie", 32'(tie_a), 1);
    mode = 2'b00; tick();
    chk("t2_reopen_valid", 32'(valid_a), 0);
    chk("t2_reopen_tie", 32'(tie_a), 0);
    clear_then_vote_mode();

    // 3: invalid one-hot, and level-held confirm
    voter = 4'b0110; confirm = 1'b1; tick();
    chk("t3_err", 32'(err_a), 1);
    chk("t3_no_ack", 32'(ack_a), 0);
    confirm = 1'b0; tick();
    chk("t3_err_low", 32'(err_a), 0);
    chk("t3_total0", 32'(tot_a), 0);
    voter = 4'b0001; confirm = 1'b1;
    acks = 0; errs = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acks += int'(ack_a);
      errs += int'(err_a);
    end
    chk("t3_held_acks", 32'(acks), 1);
    chk("t3_held_errs", 32'(errs), 0);
    confirm = 1'b0; rd_sel = 2'd0; tick();
    chk("t3_cnt0", 32'(rdc_a), 1);
    clear_then_vote_mode();

    // 4: saturation on the CNT_W=2 instance
    acks = 0; errs = 0;
    for (int k = 0; k < 5; k++) begin
      voter = 4'b0001; confirm = 1'b1; tick();
      acks += int'(ack_b);
      errs += int'(err_b);
      chk("t4_not_both", 32'(ack_b & err_b), 0);
      confirm = 1'b0; tick();
    end
    chk("t4_acks", 32'(acks), 3);
    chk("t4_errs", 32'(errs), 2);
    rd_sel = 2'd0; tick();
    chk("t4_rdcount", 32'(rdc_b), 3);
    chk("t4_total", 32'(tot_b), 3);
    chk("t4_wide_total", 32'(tot_a), 5);
    clear_then_vote_mode();

    // 5: clear mid-scan, then reset during a vote
    vote(4'b0010);
    mode = 2'b01; tick(3);
    mode = 2'b10; tick();
    chk("t5_valid", 32'(valid_a), 0);
    chk("t5_total", 32'(tot_a), 0);
    mode = 2'b00; rd_sel = 2'd1; tick();
    chk("t5_cnt1", 32'(rdc_a), 0);
    voter = 4'b0100; confirm = 1'b1; tick();
    chk("t5_open_ack", 32'(ack_a), 1);
    confirm = 1'b0; tick();
    voter = 4'b1000; confirm = 1'b1; rst = 1'b1; tick();
    chk("t5_rst_ack", 32'(ack_a), 0);
    chk("t5_rst_total", 32'(tot_a), 0);
    rst = 1'b0; confirm = 1'b0; tick();

    // 6: scan with no votes, then a single vote
    mode = 2'b01; tick(5);
    chk("t6_valid", 32'(valid_a), 1);
    chk("t6_winner0", 32'(win_a), 0);
    chk("t6_tie0", 32'(tie_a), 0);
    confirm = 1'b1; tick();
    chk("t6_err_in_done", 32'(err_a), 1);
    confirm = 1'b0;
    mode = 2'b00; tick();
    vote(4'b1000);
    mode = 2'b01; tick(5);
    chk("t6_winner", 32'(win_a), 32'b1000);
    chk("t6_tie", 32'(tie_a), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
